opcode_fetch: RTL and testbench

OPCODE_FETCH -- requirements
Module: opcode_fetch

---
 rtl/v6502_pkg.sv | 33 +++
 rtl/opcode_mode_decode.sv | 80 ++++++++
 rtl/opcode_fetch.sv | 132 +++++++++++++
 tb/tb_opcode_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/v6502_pkg.sv
// Shared 6502 front-end types: fetch states, addressing-mode and index codes.
// Used by opcode_fetch, its decoder and the address stage.
package v6502_pkg;

  typedef enum logic [2:0] {
    S_VEC_LO  = 3'd0,
    S_VEC_HI  = 3'd1,
    S_FETCH   = 3'd2,
    S_DECODE  = 3'd3,
    S_WAIT_EA = 3'd4,
    S_EXEC    = 3'd5
  } fetch_state_t;

  typedef enum logic [2:0] {
    MODE_IMM  = 3'd0,
    MODE_ABS  = 3'd1,
    MODE_ZPG  = 3'd2,
    MODE_ABSI = 3'd3,
    MODE_ZPGI = 3'd4,
    MODE_INDI = 3'd5,
    MODE_INDA = 3'd6,
    MODE_INDZ = 3'd7
  } addr_mode_t;

  typedef enum logic {
    IDX_X = 1'b0,
    IDX_Y = 1'b1
  } index_reg_t;

  localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
  localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

endpackage

// File: rtl/opcode_mode_decode.sv
// Combinational opcode -> addressing mode / index / implied / illegal decode.
// Zero latency, no flow control; implied opcodes always report IMM with index X.
module opcode_mode_decode
  import v6502_pkg::*;
(
  input  logic [7:0] opcode_i,
  output addr_mode_t mode_o,
  output index_reg_t index_o,
  output logic       implied_o,
  output logic       illegal_o
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  assign aaa = opcode_i[7:5];
  assign bbb = opcode_i[4:2];
  assign cc  = opcode_i[1:0];

  always_comb begin
    mode_o    = MODE_IMM;
    index_o   = IDX_X;
    implied_o = 1'b0;
    illegal_o = 1'b0;
    case (cc)
      2'b01: begin
        case (bbb)
          3'd0: mode_o = MODE_INDZ;
          3'd1: mode_o = MODE_ZPG;
          3'd2: mode_o = MODE_IMM;
          3'd3: mode_o = MODE_ABS;
          3'd4: begin
            mode_o  = MODE_INDI;
            index_o = IDX_Y;
          end
          3'd5: mode_o = MODE_ZPGI;
          3'd6: begin
            mode_o  = MODE_ABSI;
            index_o = IDX_Y;
          end
          default: mode_o = MODE_ABSI;
        endcase
      end
      2'b10: begin
        case (bbb)
          3'd0:    mode_o = MODE_IMM;
          3'd1:    mode_o = MODE_ZPG;
          3'd3:    mode_o = MODE_ABS;
          3'd5:    mode_o = MODE_ZPGI;
          3'd7:    mode_o = MODE_ABSI;
          default: implied_o = 1'b1;
        endcase
        // STX/LDX index through Y instead of X
        if (!implied_o && (aaa == 3'b100 || aaa == 3'b101)) begin
          index_o = IDX_Y;
        end
      end
      2'b00: begin
        case (bbb)
          3'd0: begin
            if (aaa >= 3'b101) mode_o = MODE_IMM;
            else               implied_o = 1'b1;
          end
          3'd1:    mode_o = MODE_ZPG;
          3'd3:    mode_o = (aaa == 3'b011) ? MODE_INDA : MODE_ABS;
          3'd4:    mode_o = MODE_IMM;
          3'd5:    mode_o = MODE_ZPGI;
          3'd7:    mode_o = MODE_ABSI;
          default: implied_o = 1'b1;
        endcase
      end
      default: begin
        implied_o = 1'b1;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/opcode_fetch.sv
// Reset-vector load, opcode fetch and decode handoff to the address stage.
// One opcode byte per FETCH cycle; holds in WAIT_EA/EXEC until i_ea_done/i_exec_ack.
module opcode_fetch
  import v6502_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  output logic [15:0] o_addr,
  output logic        o_bus_own,
  output logic [15:0] o_pc,
  output logic [7:0]  o_opcode,
  output logic [2:0]  o_mode,
  output logic        o_index_reg,
  output logic        o_start,
  input  logic        i_pc_inc,
  input  logic        i_ea_done,
  output logic        o_implied,
  output logic        o_illegal,
  output logic        o_valid,
  input  logic        i_exec_ack,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_value
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   opcode_q, opcode_d;
  addr_mode_t   mode_q, mode_d;
  index_reg_t   index_q, index_d;
  logic         implied_q, implied_d;
  logic         illegal_q, illegal_d;

  addr_mode_t   dec_mode;
  index_reg_t   dec_index;
  logic         dec_implied;
  logic         dec_illegal;

  opcode_mode_decode u_decode (
    .opcode_i  (opcode_q),
    .mode_o    (dec_mode),
    .index_o   (dec_index),
    .implied_o (dec_implied),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    mode_d    = mode_q;
    index_d   = index_q;
    implied_d = implied_q;
    illegal_d = illegal_q;
    o_addr    = 16'h0000;
    o_bus_own = 1'b0;
    o_start   = 1'b0;
    o_valid   = 1'b0;
    case (state_q)
      S_VEC_LO: begin
        o_addr    = RESET_VEC_LO;
        o_bus_own = 1'b1;
        pc_d      = {pc_q[15:8], i_data};
        state_d   = S_VEC_HI;
      end
      S_VEC_HI: begin
        o_addr    = RESET_VEC_HI;
        o_bus_own = 1'b1;
        pc_d      = {i_data, pc_q[7:0]};
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        o_addr    = pc_q;
        o_bus_own = 1'b1;
        opcode_d  = i_data;
        pc_d      = pc_q + 16'd1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        mode_d    = dec_mode;
        index_d   = dec_index;
        implied_d = dec_implied;
        illegal_d = dec_illegal;
        if (dec_implied) begin
          state_d = S_EXEC;
        end else begin
          o_start = 1'b1;
          state_d = S_WAIT_EA;
        end
      end
      S_WAIT_EA: begin
        // an operand byte consumed alongside i_ea_done still counts
        pc_d = pc_q + {15'd0, i_pc_inc};
        if (i_ea_done) state_d = S_EXEC;
      end
      S_EXEC: begin
        o_valid = 1'b1;
        if (i_pc_load)  pc_d    = i_pc_value;
        if (i_exec_ack) state_d = S_FETCH;
      end
      default: state_d = S_VEC_LO;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_VEC_LO;
      pc_q      <= 16'h0000;
      opcode_q  <= 8'h00;
      mode_q    <= MODE_IMM;
      index_q   <= IDX_X;
      implied_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      mode_q    <= mode_d;
      index_q   <= index_d;
      implied_q <= implied_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_pc        = pc_q;
  assign o_opcode    = opcode_q;
  assign o_mode      = mode_q;
  assign o_index_reg = index_q;
  assign o_implied   = implied_q;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Directed bench for opcode_fetch: flat memory model on o_addr, address-stage
// and execute handshakes driven on falling edges, outputs sampled there too.
module tb_opcode_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_data;
  logic [15:0] o_addr;
  logic        o_bus_own;
  logic [15:0] o_pc;
  logic [7:0]  o_opcode;
  logic [2:0]  o_mode;
  logic        o_index_reg;
  logic        o_start;
  logic        i_pc_inc;
  logic        i_ea_done;
  logic        o_implied;
  logic        o_illegal;
  logic        o_valid;
  logic        i_exec_ack;
  logic        i_pc_load;
  logic [15:0] i_pc_value;

  logic [7:0]  mem [0:65535];
  int          n_tests;
  int          n_fail;

  opcode_fetch dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .o_addr      (o_addr),
    .o_bus_own   (o_bus_own),
    .o_pc        (o_pc),
    .o_opcode    (o_opcode),
    .o_mode      (o_mode),
    .o_index_reg (o_index_reg),
    .o_start     (o_start),
    .i_pc_inc    (i_pc_inc),
    .i_ea_done   (i_ea_done),
    .o_implied   (o_implied),
    .o_illegal   (o_illegal),
    .o_valid     (o_valid),
    .i_exec_ack  (i_exec_ack),
    .i_pc_load   (i_pc_load),
    .i_pc_value  (i_pc_value)
  );

  assign i_data = mem[o_addr];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9;
    repeat (2) cyc();
    n_tests++; if (o_addr !== 16'hFFFC) begin n_fail++; $display("FAIL rst_addr: got %h want FFFC", o_addr); end
    n_tests++; if (o_bus_own !== 1'b1) begin n_fail++; $display("FAIL rst_bus_own: got %b want 1", o_bus_own); end
    n_tests++; if (o_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", o_pc); end
    n_tests++; if (o_opcode !== 8'h00) begin n_fail++; $display("FAIL rst_opcode: got %h want 00", o_opcode); end
    n_tests++; if ({o_start, o_valid, o_implied, o_illegal, o_index_reg} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", {o_start, o_valid, o_implied, o_illegal, o_index_reg}); end
    i_rst_n = 1'b1;
    cyc();
    n_tests++; if (o_addr !== 16'hFFFD) begin n_fail++; $display("FAIL vec_hi_addr: got %h want FFFD", o_addr); end
    cyc();
    n_tests++; if (o_addr !== 16'h8000 || o_bus_own !== 1'b1) begin n_fail++; $display("FAIL fetch_addr: got %h own %b want 8000 own 1", o_addr, o_bus_own); end
    cyc();
    n_tests++; if (o_start !== 1'b1 || o_bus_own !== 1'b0) begin n_fail++; $display("FAIL lda_start: got start %b own %b want 1 0", o_start, o_bus_own); end
    n_tests++; if (o_pc !== 16'h8001 || o_opcode !== 8'hA9) begin n_fail++; $display("FAIL lda_pc_op: got %h/%h want 8001/A9", o_pc, o_opcode); end
    cyc();
    n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL lda_start_once: got %b want 0", o_start); end
    n_tests++; if (o_mode !== 3'd0 || o_implied !== 1'b0) begin n_fail++; $display("FAIL lda_mode: got %0d impl %b want 0 0", o_mode, o_implied); end
    i_ea_done = 1'b1;
    cyc();
    i_ea_done = 1'b0;
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lda_valid: got %b want 1", o_valid); end
    i_exec_ack = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    n_tests++; if (o_addr !== 16'h8001 || o_valid !== 1'b0) begin n_fail++; $display("FAIL lda_next_fetch: got %h valid %b want 8001 0", o_addr, o_valid); end
  endtask

  task automatic test_operand_bytes();
    mem[16'h8001] = 8'hBD;
    i_pc_inc = 1'b1;
    cyc();
    n_tests++; if (o_pc !== 16'h8002 || o_start !== 1'b1) begin n_fail++; $display("FAIL bd_decode: got pc %h start %b want 8002 1", o_pc, o_start); end
    cyc();
    n_tests++; if (o_pc !== 16'h8002) begin n_fail++; $display("FAIL bd_inc_ignored: got %h want 8002", o_pc); end
    n_tests++; if (o_mode !== 3'd3 || o_index_reg !== 1'b0) begin n_fail++; $display("FAIL bd_mode: got %0d idx %b want 3 0", o_mode, o_index_reg); end
    cyc();
    n_tests++; if (o_pc !== 16'h8003) begin n_fail++; $display("FAIL bd_inc1: got %h want 8003", o_pc); end
    cyc();
    i_pc_inc  = 1'b0;
    i_ea_done = 1'b1;
    cyc();
    i_ea_done = 1'b0;
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h8004) begin n_fail++; $display("FAIL bd_exec: got valid %b pc %h want 1 8004", o_valid, o_pc); end
    cyc();
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bd_hold_exec: got %b want 1", o_valid); end
    i_exec_ack = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    n_tests++; if (o_addr !== 16'h8004 || o_bus_own !== 1'b1) begin n_fail++; $display("FAIL bd_next_fetch: got %h own %b want 8004 1", o_addr, o_bus_own); end
  endtask

  task automatic test_inc_with_done();
    mem[16'h8004] = 8'hB6;
    cyc();
    cyc();
    n_tests++; if (o_mode !== 3'd4 || o_index_reg !== 1'b1) begin n_fail++; $display("FAIL b6_mode: got %0d idx %b want 4 1", o_mode, o_index_reg); end
    i_pc_inc  = 1'b1;
    i_ea_done = 1'b1;
    cyc();
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h8006) begin n_fail++; $display("FAIL b6_inc_done: got valid %b pc %h want 1 8006", o_valid, o_pc); end
    cyc();
    n_tests++; if (o_pc !== 16'h8006 || o_valid !== 1'b1) begin n_fail++; $display("FAIL b6_exec_ignore: got pc %h valid %b want 8006 1", o_pc, o_valid); end
    i_pc_inc   = 1'b0;
    i_ea_done  = 1'b0;
    i_exec_ack = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    n_tests++; if (o_addr !== 16'h8006) begin n_fail++; $display("FAIL b6_next_fetch: got %h want 8006", o_addr); end
  endtask

  task automatic test_implied_illegal();
    mem[16'h8006] = 8'hEA;
    mem[16'h8007] = 8'h03;
    cyc();
    n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL nop_no_start: got %b want 0", o_start); end
    cyc();
    n_tests++; if (o_valid !== 1'b1 || o_implied !== 1'b1 || o_illegal !== 1'b0) begin n_fail++; $display("FAIL nop_exec: got v%b i%b x%b want 1 1 0", o_valid, o_implied, o_illegal); end
    n_tests++; if (o_mode !== 3'd0 || o_pc !== 16'h8007) begin n_fail++; $display("FAIL nop_mode_pc: got %0d %h want 0 8007", o_mode, o_pc); end
    i_exec_ack = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    cyc();
    n_tests++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL ill_no_start: got %b want 0", o_start); end
    cyc();
    n_tests++; if (o_illegal !== 1'b1 || o_implied !== 1'b1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL ill_flags: got x%b i%b v%b want 1 1 1", o_illegal, o_implied, o_valid); end
    i_exec_ack = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    n_tests++; if (o_addr !== 16'h8008) begin n_fail++; $display("FAIL ill_next_fetch: got %h want 8008", o_addr); end
  endtask

  task automatic test_corner_modes();
    logic [7:0]  ops  [7];
    logic [2:0]  mds  [7];
    logic        idxs [7];
    logic [15:0] pc;
    ops  = '{8'h6C, 8'hB1, 8'hA1, 8'h4C, 8'h10, 8'h96, 8'hBE};
    mds  = '{3'd6,  3'd5,  3'd7,  3'd1,  3'd0,  3'd4,  3'd3};
    idxs = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    pc = 16'h8008;
    for (int i = 0; i < 7; i++) begin
      mem[pc] = ops[i];
      cyc();
      n_tests++; if (o_start !== 1'b1) begin n_fail++; $display("FAIL corner_start op %h: got %b want 1", ops[i], o_start); end
      cyc();
      n_tests++; if (o_mode !== mds[i] || o_index_reg !== idxs[i] || o_implied !== 1'b0) begin n_fail++; $display("FAIL corner_mode op %h: got mode %0d idx %b impl %b want %0d %b 0", ops[i], o_mode, o_index_reg, o_implied, mds[i], idxs[i]); end
      i_ea_done = 1'b1;
      cyc();
      i_ea_done  = 1'b0;
      i_exec_ack = 1'b1;
      cyc();
      i_exec_ack = 1'b0;
      pc = pc + 16'd1;
      n_tests++; if (o_addr !== pc) begin n_fail++; $display("FAIL corner_next op %h: got %h want %h", ops[i], o_addr, pc); end
    end
  endtask

  task automatic test_wrap_jump();
    mem[16'h800F] = 8'hEA;
    mem[16'hFFFF] = 8'hEA;
    mem[16'h1234] = 8'hBD;
    cyc();
    cyc();
    i_pc_load  = 1'b1;
    i_pc_value = 16'hFFFF;
    cyc();
    n_tests++; if (o_pc !== 16'hFFFF || o_valid !== 1'b1) begin n_fail++; $display("FAIL load_no_ack: got pc %h valid %b want FFFF 1", o_pc, o_valid); end
    i_exec_ack = 1'b1;
    cyc();
    i_pc_load  = 1'b0;
    i_exec_ack = 1'b0;
    n_tests++; if (o_addr !== 16'hFFFF) begin n_fail++; $display("FAIL fetch_ffff: got %h want FFFF", o_addr); end
    cyc();
    n_tests++; if (o_pc !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h want 0000", o_pc); end
    cyc();
    i_pc_load  = 1'b1;
    i_pc_value = 16'h1234;
    i_exec_ack = 1'b1;
    i_pc_inc   = 1'b1;
    cyc();
    i_exec_ack = 1'b0;
    i_pc_inc   = 1'b0;
    i_pc_value = 16'h5555;
    n_tests++; if (o_addr !== 16'h1234) begin n_fail++; $display("FAIL jump_fetch: got %h want 1234", o_addr); end
    cyc();
    i_pc_load = 1'b0;
    n_tests++; if (o_pc !== 16'h1235) begin n_fail++; $display("FAIL load_outside_exec: got %h want 1235", o_pc); end
    cyc();
  endtask

  task automatic test_reset_mid();
    i_pc_inc = 1'b1;
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++; if (o_addr !== 16'hFFFC || o_bus_own !== 1'b1) begin n_fail++; $display("FAIL mid_rst_addr: got %h own %b want FFFC 1", o_addr, o_bus_own); end
    n_tests++; if (o_pc !== 16'h0000 || o_mode !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got pc %h mode %0d valid %b want 0000 0 0", o_pc, o_mode, o_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++; if ({o_start, o_valid} !== 2'b00 || o_addr !== 16'hFFFC) begin n_fail++; $display("FAIL mid_rst_hold %0d: got s%b v%b addr %h want 0 0 FFFC", i, o_start, o_valid, o_addr); end
    end
    i_rst_n  = 1'b1;
    i_pc_inc = 1'b0;
    cyc();
    n_tests++; if (o_addr !== 16'hFFFD || o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vec_hi: got %h valid %b want FFFD 0", o_addr, o_valid); end
    cyc();
    n_tests++; if (o_addr !== 16'h8000) begin n_fail++; $display("FAIL mid_rst_refetch: got %h want 8000", o_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    i_rst_n    = 1'b0;
    i_pc_inc   = 1'b0;
    i_ea_done  = 1'b0;
    i_exec_ack = 1'b0;
    i_pc_load  = 1'b0;
    i_pc_value = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_operand_bytes();
    test_inc_with_done();
    test_implied_illegal();
    test_corner_modes();
    test_wrap_jump();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
